dm_load_unit: RTL

//  Load-side counterpart of the data memory store path: accepts one load (lw/lb/lbu/lh/lhu)

---
 rtl/dm_load_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dm_load_unit.sv
// Load path of the data memory: issues one word read per load, extracts the byte/halfword
// lane (little-endian), sign/zero-extends it and returns it over a valid/ready handshake.
module dm_load_unit #(
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_pc,
  output logic              mem_re,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic [31:0]       rsp_pc,
  output logic              busy
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_RESP} state_t;
  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LB  = 3'b001,
    OP_LBU = 3'b010,
    OP_LH  = 3'b011,
    OP_LHU = 3'b100
  } op_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_op;
  logic [1:0]        r_lane;
  logic [31:0]       r_pc;
  logic [31:0]       r_data;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_legal_op;
  logic              w_misalign;
  logic              w_go_read;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ext;

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;
  assign rsp_pc    = r_pc;

  // Reset dominates, so a request presented during reset is never accepted.
  assign w_accept   = req_valid & req_ready & ~reset;
  assign w_legal_op = (req_op <= OP_LHU);
  assign w_misalign = ((req_op == OP_LW) && (req_addr[1:0] != 2'b00)) ||
                      (((req_op == OP_LH) || (req_op == OP_LHU)) && req_addr[0]);
  assign w_go_read  = w_accept & w_legal_op & ~w_misalign;

  assign mem_re   = w_go_read;
  assign mem_addr = req_addr[ADDR_W-1:2];

  always_comb begin
    w_byte = 8'h00;
    case (r_lane)
      2'b00:   w_byte = mem_rdata[7:0];
      2'b01:   w_byte = mem_rdata[15:8];
      2'b10:   w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_op)
      OP_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_ext = {24'h000000, w_byte};
      OP_LH:   w_ext = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_ext = {16'h0000, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_go_read ? ST_READ : ST_RESP;
      ST_READ: if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_lane  <= '0;
      r_pc    <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= req_op;
        r_lane <= req_addr[1:0];
        r_pc   <= req_pc;
        r_data <= '0;
        r_err  <= ~w_go_read;
        r_cnt  <= CNT_W'(MEM_LAT - 1);
      end
      // Counter reaches zero in the cycle the RAM word is valid (MEM_LAT after mem_re).
      if (r_state == ST_READ) begin
        if (r_cnt == '0) r_data <= w_ext;
        else             r_cnt  <= r_cnt - 1'b1;
      end
    end
  end

endmodule
